// File: rtl/scan_pkg.sv
// Shared types for the scan sequencer: the two-state scan controller encoding.
package scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

endpackage

// File: rtl/scan_dwell_counter.sv
// Per-channel dwell timer: counts 0..dwell_lat, flags the last cycle of a channel,
// and rolls back to zero on that cycle so the next channel starts fresh.
module scan_dwell_counter #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell_lat,
    output logic [DWELL_W-1:0] count,
    output logic               tc
);

    logic [DWELL_W-1:0] count_q, count_d;

    assign tc    = (count_q == dwell_lat);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/scan_sequencer_nbit.sv
// Channel scan sequencer feeding an N-bit one-hot decoder (a/enable).
// Define SCAN_SKIP_MASK_EN to add skip_mask, which removes channels from the scan.
//
// state | meaning
// IDLE  | enable low, waiting for start (without stop)
// SCAN  | presenting channel a for dwell+1 cycles, then advancing
module scan_sequencer_nbit
    import scan_pkg::*;
#(
    parameter int N       = 3,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
    output logic [N-1:0]       a,
    output logic               enable,
    output logic               busy,
    output logic               done,
    output logic               wrap
`ifdef SCAN_SKIP_MASK_EN
    ,
    input  logic [2**N-1:0]    skip_mask
`endif
);

    localparam int NCH = 2**N;

    scan_state_e        state_q, state_d;
    logic [N-1:0]       a_q, a_d;
    logic               enable_q, enable_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;
    logic               cont_q, cont_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic               cnt_clear;
    logic               cnt_tc;
    logic [DWELL_W-1:0] cnt_value;

    logic [NCH-1:0]     mask_sel;
    logic [N-1:0]       first_ch, last_ch, next_ch;
    logic               all_masked;

`ifdef SCAN_SKIP_MASK_EN
    logic [NCH-1:0]     mask_q, mask_d;

    // In IDLE the mask is being latched this cycle, so the first channel comes from the port.
    assign mask_sel = (state_q == IDLE) ? skip_mask : mask_q;

    always_comb begin
        mask_d = mask_q;
        if (state_q == IDLE && start && !stop) begin
            mask_d = skip_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end
`else
    assign mask_sel = '0;
`endif

    always_comb begin
        first_ch   = '0;
        last_ch    = '0;
        next_ch    = '0;
        all_masked = &mask_sel;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!mask_sel[i]) first_ch = N'(i);
        end
        for (int i = 0; i < NCH; i++) begin
            if (!mask_sel[i]) last_ch = N'(i);
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!mask_sel[i] && i > int'(a_q)) next_ch = N'(i);
        end
    end

    scan_dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (cnt_clear),
        .en        (state_q == SCAN),
        .dwell_lat (dwell_q),
        .count     (cnt_value),
        .tc        (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        enable_d  = enable_q;
        done_d    = 1'b0;
        wrap_d    = 1'b0;
        cont_d    = cont_q;
        dwell_d   = dwell_q;
        cnt_clear = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                a_d       = '0;
                enable_d  = 1'b0;
                if (start && !stop) begin
                    cont_d  = continuous;
                    dwell_d = dwell;
                    // Nothing to present: finish immediately, even in continuous mode.
                    if (all_masked) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = SCAN;
                        a_d      = first_ch;
                        enable_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d   = IDLE;
                    a_d       = '0;
                    enable_d  = 1'b0;
                    cnt_clear = 1'b1;
                end else if (cnt_tc) begin
                    if (a_q == last_ch) begin
                        if (cont_q) begin
                            a_d    = first_ch;
                            wrap_d = 1'b1;
                        end else begin
                            state_d  = IDLE;
                            a_d      = '0;
                            enable_d = 1'b0;
                            done_d   = 1'b1;
                        end
                    end else begin
                        a_d = next_ch;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                a_d      = '0;
                enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            cont_q   <= 1'b0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            enable_q <= enable_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
            cont_q   <= cont_d;
            dwell_q  <= dwell_d;
        end
    end

    assign a      = a_q;
    assign enable = enable_q;
    assign busy   = (state_q == SCAN);
    assign done   = done_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_scan_sequencer_nbit.sv
// Bench for scan_sequencer_nbit: directed and randomized scans compared against
// an expected per-cycle trace built from the channel list and dwell.
module tb_scan_sequencer_nbit;

    localparam int N   = 3;
    localparam int DW  = 4;
    localparam int NCH = 8;

    localparam logic [6:0] IDLE_E = 7'h00;
    localparam logic [6:0] DONE_E = 7'h02;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic          continuous;
    logic [DW-1:0] dwell;
    logic [N-1:0]  a;
    logic          enable;
    logic          busy;
    logic          done;
    logic          wrap;
`ifdef SCAN_SKIP_MASK_EN
    logic [NCH-1:0] skip_mask;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    scan_sequencer_nbit #(
        .N       (N),
        .DWELL_W (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .dwell      (dwell),
        .a          (a),
        .enable     (enable),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap)
`ifdef SCAN_SKIP_MASK_EN
        ,
        .skip_mask  (skip_mask)
`endif
    );

    // Observed outputs packed as {a, enable, busy, done, wrap}.
    function automatic logic [6:0] obs();
        return {a, enable, busy, done, wrap};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs from the cycle after start: each unmasked channel in
    // ascending order for dwell+1 cycles, wrap flagged on re-entry to the first
    // channel, and a done cycle closing a single pass (or an all-masked start).
    task automatic build(input bit cont, input int d, input logic [7:0] mask, input int npass);
        int chans[$];
        exp_q.delete();
        for (int i = 0; i < NCH; i++) if (!mask[i]) chans.push_back(i);
        if (chans.size() == 0) begin
            exp_q.push_back(DONE_E);
            return;
        end
        for (int p = 0; p < npass; p++)
            foreach (chans[c])
                for (int k = 0; k <= d; k++)
                    exp_q.push_back({3'(chans[c]), 1'b1, 1'b1, 1'b0,
                                     (p > 0 && c == 0 && k == 0)});
        if (!cont) exp_q.push_back(DONE_E);
    endtask

    // stop_idx = -2 picks a random stop point; -1 means no stop (single mode only).
    task automatic run_scan(input bit cont, input int d, input logic [7:0] mask,
                            input int npass, input int stop_idx, input int poke_idx);
        int sidx;
        int len;
        build(cont, d, mask, npass);
        len  = exp_q.size();
        sidx = stop_idx;
        if (sidx == -2) begin
            if (exp_q[0] == DONE_E) sidx = -1;
            else if (cont) sidx = $urandom_range(0, len - 1);
            else sidx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 2) : -1;
        end
        if (cont && sidx < 0 && exp_q[0] != DONE_E) sidx = len - 1;
        continuous = cont;
        dwell      = DW'(d);
`ifdef SCAN_SKIP_MASK_EN
        skip_mask  = mask;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int idx = 0; idx < len; idx++) begin
            chk($sformatf("scan c%0d d%0d m%02h [%0d]", cont, d, mask, idx), obs(), exp_q[idx]);
            // Mid-scan input changes must not matter.
            continuous = 1'($urandom);
            dwell      = DW'($urandom);
`ifdef SCAN_SKIP_MASK_EN
            skip_mask  = NCH'($urandom);
`endif
            start = (idx == poke_idx);
            if (idx == sidx) begin
                stop = 1'b1;
                tick();
                stop  = 1'b0;
                start = 1'b0;
                chk($sformatf("stop idle [%0d]", idx), obs(), IDLE_E);
                tick();
                chk("post-stop idle", obs(), IDLE_E);
                return;
            end
            tick();
            start = 1'b0;
        end
        chk("post-done idle", obs(), IDLE_E);
    endtask

    initial begin
        logic [7:0] rmask;
        reset      = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        continuous = 1'b0;
        dwell      = '0;
`ifdef SCAN_SKIP_MASK_EN
        skip_mask  = '0;
`endif
        tick();
        tick();
        chk("reset state", obs(), IDLE_E);
        reset = 1'b0;
        tick();
        chk("idle after reset", obs(), IDLE_E);

        run_scan(1'b0, 0, 8'h00, 1, -1, -1);
        run_scan(1'b0, 2, 8'h00, 1, -1, -1);
        run_scan(1'b1, 0, 8'h00, 3, 19, -1);

        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start+stop idle", obs(), IDLE_E);
        tick();
        chk("start+stop idle 2", obs(), IDLE_E);

        run_scan(1'b0, 0, 8'h00, 1, -1, 4);

        continuous = 1'b1;
        dwell      = 4'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre-reset scanning", obs(), {3'd1, 1'b1, 1'b1, 1'b0, 1'b0});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid-scan reset", obs(), IDLE_E);
        tick();
        chk("mid-scan reset no done", obs(), IDLE_E);

`ifdef SCAN_SKIP_MASK_EN
        run_scan(1'b0, 0, 8'h55, 1, -1, -1);
        run_scan(1'b0, 0, 8'hFF, 1, -1, -1);
        run_scan(1'b1, 1, 8'hFF, 2, -1, -1);
        run_scan(1'b1, 0, 8'h7E, 3, -2, -1);
`endif

        repeat (30) begin
`ifdef SCAN_SKIP_MASK_EN
            rmask = 8'($urandom);
`else
            rmask = 8'h00;
`endif
            if ($urandom_range(0, 1) == 1)
                run_scan(1'b1, $urandom_range(0, 3), rmask, $urandom_range(2, 3), -2, -1);
            else
                run_scan(1'b0, $urandom_range(0, 3), rmask, 1, -2, $urandom_range(0, 6));
            repeat ($urandom_range(0, 2)) begin
                tick();
                chk("idle gap", obs(), IDLE_E);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
